// File: rtl/inst_fetch_bus_pkg.sv
// Shared constants, FSM encoding and buffer payload for the instruction fetch bus unit.
package inst_fetch_bus_pkg;

   localparam int unsigned ADDR_W       = 32;
   localparam int unsigned DATA_W       = 32;
   localparam int unsigned STALL_W      = 6;
   localparam int unsigned STALL_IF_BIT = 1;
   localparam int unsigned STALL_ID_BIT = 2;

   localparam logic RST_ACTIVE   = 1'b0;
   localparam logic STALL_ACTIVE = 1'b1;
   localparam logic WRITE_ENABLE = 1'b1;

   localparam logic [DATA_W-1:0] NOP = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_DISCARD = 2'd2,
      ST_HOLD    = 2'd3
   } fetch_state_t;

   // One-entry buffer for a response that arrived while IF/ID was frozen
   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] inst;
      logic              err;
   } fetch_buf_t;

endpackage

// File: rtl/inst_fetch_bus.sv
// Instruction fetch bus master: issues one read per fetch, handles redirects,
// stalls and bus errors, and drives the registered IF/ID payload.
module inst_fetch_bus
   import inst_fetch_bus_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic [ADDR_W-1:0]  pc,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic               mem_ack,
   input  logic [DATA_W-1:0]  mem_rdata,
   input  logic               mem_err,
   output logic               stall_request,
   output logic [ADDR_W-1:0]  id_pc,
   output logic [DATA_W-1:0]  id_inst,
   output logic               id_valid,
   output logic               exc_fetch
);

   fetch_state_t      r_state;
   logic              r_mem_req;
   logic [ADDR_W-1:0] r_mem_addr;
   fetch_buf_t        r_buf;
   logic [ADDR_W-1:0] r_id_pc;
   logic [DATA_W-1:0] r_id_inst;
   logic              r_id_valid;
   logic              r_exc_fetch;

   logic              w_stall_if;
   logic              w_stall_id;
   logic              w_pc_aligned;
   logic              w_stall_req;
   logic              w_load;
   logic [ADDR_W-1:0] w_load_pc;
   logic [DATA_W-1:0] w_load_inst;
   logic              w_load_err;
   logic              w_unused_stall;

   assign w_stall_if     = (stall[STALL_IF_BIT] == STALL_ACTIVE);
   assign w_stall_id     = (stall[STALL_ID_BIT] == STALL_ACTIVE);
   assign w_pc_aligned   = (pc[1:0] == 2'b00);
   assign w_unused_stall = ^{stall[5:3], stall[0]};

   // Freeze request to the pipeline controller; a redirect always wins
   always_comb begin
      w_stall_req = 1'b0;
      if (!flush) begin
         case (r_state)
            ST_IDLE:    w_stall_req = w_pc_aligned;
            ST_WAIT:    w_stall_req = !mem_ack;
            ST_DISCARD: w_stall_req = 1'b1;
            ST_HOLD:    w_stall_req = w_stall_if;
            default:    w_stall_req = 1'b0;
         endcase
      end
   end

   // Select what (if anything) is written into IF/ID this cycle
   always_comb begin
      w_load      = 1'b0;
      w_load_pc   = pc;
      w_load_inst = NOP;
      w_load_err  = 1'b0;
      if (!flush && !w_stall_if) begin
         case (r_state)
            ST_IDLE: begin
               if (!w_pc_aligned) begin
                  w_load     = WRITE_ENABLE;
                  w_load_pc  = pc;
                  w_load_err = 1'b1;
               end
            end
            ST_WAIT: begin
               if (mem_ack) begin
                  w_load      = WRITE_ENABLE;
                  w_load_pc   = r_mem_addr;
                  w_load_inst = mem_err ? NOP : mem_rdata;
                  w_load_err  = mem_err;
               end
            end
            ST_HOLD: begin
               w_load      = WRITE_ENABLE;
               w_load_pc   = r_buf.pc;
               w_load_inst = r_buf.inst;
               w_load_err  = r_buf.err;
            end
            default: ;
         endcase
      end
   end

   // Fetch FSM with registered bus request and response buffer
   always_ff @(posedge clock) begin
      if (reset == RST_ACTIVE) begin
         r_state    <= ST_IDLE;
         r_mem_req  <= 1'b0;
         r_mem_addr <= '0;
         r_buf      <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pc_aligned && !flush) begin
                  r_mem_req  <= 1'b1;
                  r_mem_addr <= pc;
                  r_state    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (mem_ack) begin
                  r_mem_req <= 1'b0;
                  if (!flush && w_stall_if) begin
                     r_buf.pc   <= r_mem_addr;
                     r_buf.inst <= mem_err ? NOP : mem_rdata;
                     r_buf.err  <= mem_err;
                     r_state    <= ST_HOLD;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end else if (flush) begin
                  r_state <= ST_DISCARD;
               end
            end
            ST_DISCARD: begin
               if (mem_ack) begin
                  r_mem_req <= 1'b0;
                  r_state   <= ST_IDLE;
               end
            end
            ST_HOLD: begin
               if (flush || !w_stall_if) begin
                  r_buf   <= '0;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_mem_req <= 1'b0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

   // IF/ID register: flush clears, stall holds or bubbles, otherwise load or bubble
   always_ff @(posedge clock) begin
      if (reset == RST_ACTIVE) begin
         r_id_pc     <= '0;
         r_id_inst   <= NOP;
         r_id_valid  <= 1'b0;
         r_exc_fetch <= 1'b0;
      end else if (flush) begin
         r_id_inst   <= NOP;
         r_id_valid  <= 1'b0;
         r_exc_fetch <= 1'b0;
      end else if (w_stall_if) begin
         if (!w_stall_id) begin
            r_id_inst   <= NOP;
            r_id_valid  <= 1'b0;
            r_exc_fetch <= 1'b0;
         end
      end else if (w_load) begin
         r_id_pc     <= w_load_pc;
         r_id_inst   <= w_load_inst;
         r_id_valid  <= 1'b1;
         r_exc_fetch <= w_load_err;
      end else begin
         r_id_inst   <= NOP;
         r_id_valid  <= 1'b0;
         r_exc_fetch <= 1'b0;
      end
   end

   assign mem_req       = r_mem_req;
   assign mem_addr      = r_mem_addr;
   assign stall_request = w_stall_req;
   assign id_pc         = r_id_pc;
   assign id_inst       = r_id_inst;
   assign id_valid      = r_id_valid;
   assign exc_fetch     = r_exc_fetch;

endmodule

// File: tb/tb_inst_fetch_bus.sv
// Self-checking bench for inst_fetch_bus: directed scenarios plus an IF/ID scoreboard.
module tb_inst_fetch_bus;

   logic        clock;
   logic        reset;
   logic [31:0] pc;
   logic [5:0]  stall;
   logic        flush;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        mem_err;
   logic        stall_request;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic        id_valid;
   logic        exc_fetch;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        exc;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   logic edge_stall_if = 1'b0;

   inst_fetch_bus dut (
      .clock         (clock),
      .reset         (reset),
      .pc            (pc),
      .stall         (stall),
      .flush         (flush),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .mem_ack       (mem_ack),
      .mem_rdata     (mem_rdata),
      .mem_err       (mem_err),
      .stall_request (stall_request),
      .id_pc         (id_pc),
      .id_inst       (id_inst),
      .id_valid      (id_valid),
      .exc_fetch     (exc_fetch)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Remember whether IF/ID was frozen at the last edge so held entries are not re-counted
   always @(posedge clock) edge_stall_if <= stall[1];

   // Scoreboard: every freshly loaded IF/ID entry must match the oldest expectation
   always @(negedge clock) begin
      if (id_valid === 1'b1 && edge_stall_if === 1'b0) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: id_pc=%h id_inst=%h exc=%b, required no valid entry",
                     id_pc, id_inst, exc_fetch);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if ({id_pc, id_inst, exc_fetch} !== {e.pc, e.inst, e.exc}) begin
               n_fail++;
               $display("FAIL sb_entry: got pc=%h inst=%h exc=%b, required pc=%h inst=%h exc=%b",
                        id_pc, id_inst, exc_fetch, e.pc, e.inst, e.exc);
            end
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic push_exp(input logic [31:0] p, input logic [31:0] i, input logic x);
      exp_t e;
      e.pc = p; e.inst = i; e.exc = x;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      reset = 1'b0; flush = 1'b1;
      step(); step();
      n_checks++;
      if ({mem_req, mem_addr, id_pc, id_inst, id_valid, exc_fetch} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: req=%b addr=%h id_pc=%h inst=%h v=%b exc=%b, required all 0",
                  mem_req, mem_addr, id_pc, id_inst, id_valid, exc_fetch);
      end
      reset = 1'b1;
      step();
      n_checks++;
      if (mem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_park_req: mem_req=%b required 0", mem_req);
      end
   endtask

   task automatic test_aligned_fetch();
      pc = 32'h100; flush = 1'b0;
      #1;
      n_checks++;
      if (stall_request !== 1'b1) begin
         n_fail++;
         $display("FAIL align_idle_stallreq: stall_request=%b required 1", stall_request);
      end
      step();
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
         n_fail++;
         $display("FAIL align_req: mem_req=%b mem_addr=%h, required 1 / 00000100", mem_req, mem_addr);
      end
      for (int k = 0; k < 3; k++) begin
         if (k > 0) step();
         n_checks++;
         if (stall_request !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL align_wait%0d: stall_request=%b mem_req=%b addr=%h, required 1/1/00000100",
                     k, stall_request, mem_req, mem_addr);
         end
      end
      mem_ack = 1'b1; mem_rdata = 32'h2401_0005;
      push_exp(32'h100, 32'h2401_0005, 1'b0);
      #1;
      n_checks++;
      if (stall_request !== 1'b0) begin
         n_fail++;
         $display("FAIL align_ack_stallreq: stall_request=%b required 0", stall_request);
      end
      step();
      mem_ack = 1'b0; flush = 1'b1;
      n_checks++;
      if (mem_req !== 1'b0 || id_valid !== 1'b1 || id_pc !== 32'h100 || id_inst !== 32'h2401_0005) begin
         n_fail++;
         $display("FAIL align_load: req=%b v=%b id_pc=%h inst=%h, required 0/1/00000100/24010005",
                  mem_req, id_valid, id_pc, id_inst);
      end
      step();
   endtask

   task automatic test_misaligned();
      pc = 32'h102; flush = 1'b0;
      push_exp(32'h102, 32'h0, 1'b1);
      #1;
      n_checks++;
      if (stall_request !== 1'b0) begin
         n_fail++;
         $display("FAIL misalign_stallreq: stall_request=%b required 0", stall_request);
      end
      step();
      flush = 1'b1;
      n_checks++;
      if (mem_req !== 1'b0 || id_pc !== 32'h102 || id_inst !== 32'h0 || exc_fetch !== 1'b1 || id_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL misalign_load: req=%b id_pc=%h inst=%h exc=%b v=%b, required 0/00000102/0/1/1",
                  mem_req, id_pc, id_inst, exc_fetch, id_valid);
      end
      step();
   endtask

   task automatic test_hold_and_bubble();
      pc = 32'h105; flush = 1'b0;
      push_exp(32'h105, 32'h0, 1'b1);
      step();
      stall = 6'b000110;
      step();
      n_checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'h105 || exc_fetch !== 1'b1) begin
         n_fail++;
         $display("FAIL ifid_hold: v=%b id_pc=%h exc=%b, required 1/00000105/1", id_valid, id_pc, exc_fetch);
      end
      stall = 6'b000010;
      step();
      n_checks++;
      if (id_valid !== 1'b0 || id_inst !== 32'h0) begin
         n_fail++;
         $display("FAIL ifid_bubble: v=%b inst=%h, required 0/00000000", id_valid, id_inst);
      end
      stall = 6'b0; flush = 1'b1;
      step();
   endtask

   task automatic test_flush_discard();
      pc = 32'h200; flush = 1'b0;
      step();
      flush = 1'b1; pc = 32'h240;
      #1;
      n_checks++;
      if (stall_request !== 1'b0) begin
         n_fail++;
         $display("FAIL discard_flush_stallreq: stall_request=%b required 0", stall_request);
      end
      step();
      flush = 1'b0;
      #1;
      n_checks++;
      if (mem_req !== 1'b1 || stall_request !== 1'b1 || id_valid !== 1'b0 || mem_addr !== 32'h200) begin
         n_fail++;
         $display("FAIL discard_state: req=%b stall_request=%b v=%b addr=%h, required 1/1/0/00000200",
                  mem_req, stall_request, id_valid, mem_addr);
      end
      mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      step();
      mem_ack = 1'b0;
      n_checks++;
      if (mem_req !== 1'b0 || id_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL discard_drop: req=%b v=%b, required 0/0", mem_req, id_valid);
      end
      step();
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h240) begin
         n_fail++;
         $display("FAIL discard_redirect: req=%b addr=%h, required 1/00000240", mem_req, mem_addr);
      end
      mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
      push_exp(32'h240, 32'h1111_2222, 1'b0);
      step();
      mem_ack = 1'b0; flush = 1'b1;
      step();
   endtask

   task automatic test_stall_buffer();
      pc = 32'h380; flush = 1'b0;
      step();
      stall = 6'b000110; mem_ack = 1'b1; mem_rdata = 32'h8C22_0004;
      push_exp(32'h380, 32'h8C22_0004, 1'b0);
      for (int k = 0; k < 2; k++) begin
         step();
         mem_ack = 1'b0; mem_rdata = 32'h0;
         #1;
         n_checks++;
         if (mem_req !== 1'b0 || id_valid !== 1'b0 || stall_request !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_cycle%0d: req=%b v=%b stall_request=%b, required 0/0/1",
                     k, mem_req, id_valid, stall_request);
         end
      end
      stall = 6'b0;
      #1;
      n_checks++;
      if (stall_request !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_release_stallreq: stall_request=%b required 0", stall_request);
      end
      step();
      flush = 1'b1;
      n_checks++;
      if (id_valid !== 1'b1 || id_inst !== 32'h8C22_0004 || id_pc !== 32'h380) begin
         n_fail++;
         $display("FAIL hold_load: v=%b inst=%h id_pc=%h, required 1/8c220004/00000380", id_valid, id_inst, id_pc);
      end
      step();
   endtask

   task automatic test_bus_error();
      pc = 32'h300; flush = 1'b0;
      step();
      mem_ack = 1'b1; mem_err = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      push_exp(32'h300, 32'h0, 1'b1);
      step();
      mem_ack = 1'b0; mem_err = 1'b0; flush = 1'b1;
      n_checks++;
      if (id_inst !== 32'h0 || exc_fetch !== 1'b1 || id_pc !== 32'h300 || id_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL bus_error: inst=%h exc=%b id_pc=%h v=%b, required 0/1/00000300/1",
                  id_inst, exc_fetch, id_pc, id_valid);
      end
      step();
   endtask

   task automatic test_flush_with_ack();
      pc = 32'h400; flush = 1'b0;
      step();
      mem_ack = 1'b1; mem_rdata = 32'h55AA_55AA; flush = 1'b1; pc = 32'h440;
      step();
      mem_ack = 1'b0;
      n_checks++;
      if (mem_req !== 1'b0 || id_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_ack_drop: req=%b v=%b, required 0/0", mem_req, id_valid);
      end
      step();
   endtask

   task automatic test_back_to_back();
      logic [31:0] a;
      int          t0;
      a = 32'h500; pc = a; flush = 1'b0;
      t0 = $time;
      for (int k = 0; k < 4; k++) begin
         step();
         n_checks++;
         if (mem_req !== 1'b1 || mem_addr !== a) begin
            n_fail++;
            $display("FAIL b2b_req%0d: req=%b addr=%h, required 1/%h", k, mem_req, mem_addr, a);
         end
         mem_ack = 1'b1; mem_rdata = 32'hA000_0000 + 32'(k);
         push_exp(a, 32'hA000_0000 + 32'(k), 1'b0);
         step();
         mem_ack = 1'b0;
         a = a + 32'd4; pc = a;
      end
      n_checks++;
      if (($time - t0) != 80) begin
         n_fail++;
         $display("FAIL b2b_rate: elapsed=%0d required 80", $time - t0);
      end
      flush = 1'b1;
      step();
   endtask

   task automatic test_reset_during_wait();
      pc = 32'h600; flush = 1'b0;
      step();
      reset = 1'b0;
      step();
      n_checks++;
      if ({mem_req, mem_addr, id_pc, id_inst, id_valid, exc_fetch} !== '0) begin
         n_fail++;
         $display("FAIL reset_wait_outputs: req=%b addr=%h id_pc=%h inst=%h v=%b exc=%b, required all 0",
                  mem_req, mem_addr, id_pc, id_inst, id_valid, exc_fetch);
      end
      reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
      step();
      mem_ack = 1'b0;
      n_checks++;
      if (id_valid !== 1'b0 || mem_req !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_late_ack: v=%b req=%b, required 0/1", id_valid, mem_req);
      end
      mem_ack = 1'b1; mem_rdata = 32'h0000_ABCD;
      push_exp(32'h600, 32'h0000_ABCD, 1'b0);
      step();
      mem_ack = 1'b0; flush = 1'b1;
      step();
   endtask

   initial begin
      reset = 1'b0; pc = 32'h0; stall = 6'b0; flush = 1'b1;
      mem_ack = 1'b0; mem_rdata = 32'h0; mem_err = 1'b0;
      test_reset();
      test_aligned_fetch();
      test_misaligned();
      test_hold_and_bubble();
      test_flush_discard();
      test_stall_buffer();
      test_bus_error();
      test_flush_with_ack();
      test_back_to_back();
      test_reset_during_wait();
      step();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: %0d expected entries never appeared, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/inst_fetch_bus.md
INST_FETCH_BUS -- requirements
Module: inst_fetch_bus

Interface
REQ-001 SHALL have port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1: synchronous, active-low reset (0 = reset), sampled on clock rising edge.
REQ-003 SHALL have port pc, input, 32: current fetch address from the PC stage.
REQ-004 SHALL have port stall, input, 6: pipeline stall vector; stall[1] = hold IF/ID, stall[2] = hold ID.
REQ-005 SHALL have port flush, input, 1: branch/jump redirect, same cycle as the PC-stage write enable.
REQ-006 SHALL have port mem_req, output, 1: instruction bus read request, level-held until ack.
REQ-007 SHALL have port mem_addr, output, 32: read address, stable while mem_req=1.
REQ-008 SHALL have ports mem_ack, input, 1, and mem_rdata, input, 32: read completion and data, valid only in the ack cycle.
REQ-009 SHALL have port mem_err, input, 1: bus error, qualified by mem_ack.
REQ-010 SHALL have port stall_request, output, 1: combinational request to the pipeline controller to freeze PC and IF.
REQ-011 SHALL have ports id_pc, id_inst (output, 32 each), id_valid and exc_fetch (output, 1 each): registered IF/ID payload.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT, DISCARD, HOLD.
REQ-013 IDLE, pc[1:0]==0, flush=0: SHALL register mem_req=1 and mem_addr=pc; next state WAIT.
REQ-014 IDLE, pc[1:0]!=0: SHALL issue no request; load IF/ID with id_pc=pc, id_inst=NOP (32'h0), exc_fetch=1, id_valid=1; stay IDLE.
REQ-015 WAIT, mem_ack=1, stall[1]=0: SHALL load id_pc=mem_addr, id_inst=mem_rdata (NOP if mem_err), exc_fetch=mem_err, id_valid=1; drop mem_req; next IDLE.
REQ-016 WAIT, mem_ack=1, stall[1]=1: SHALL capture data/err in a one-entry buffer; drop mem_req; next HOLD.
REQ-017 HOLD: SHALL load IF/ID from buffer on first cycle with stall[1]=0; next IDLE.
REQ-018 WAIT, flush=1, mem_ack=0: next DISCARD; mem_req stays 1 until ack.
REQ-019 WAIT, flush=1 and mem_ack=1 in same cycle: SHALL drop the data; next IDLE.
REQ-020 DISCARD: SHALL ignore mem_rdata/mem_err; on mem_ack drop mem_req, next IDLE.
REQ-021 HOLD, flush=1: SHALL discard buffer; next IDLE.
REQ-022 stall_request SHALL be 1 in IDLE-with-aligned-pc, WAIT without ack, DISCARD, and HOLD with stall[1]=1; 0 otherwise; SHALL be forced 0 whenever flush=1 so the redirect lands.
REQ-023 flush=1 SHALL clear id_valid, id_inst, exc_fetch to 0 next cycle, overriding any load.
REQ-024 stall[1]=1 and stall[2]=0: IF/ID SHALL output bubble (id_valid=0, id_inst=NOP); stall[1]=1 and stall[2]=1: IF/ID SHALL hold.
REQ-025 mem_ack outside WAIT/DISCARD SHALL be ignored.
REQ-026 Minimum latency: request 1 cycle after IDLE entry; data on IF/ID 1 cycle after ack; zero-wait bus gives one instruction per 2 cycles.

Reset
REQ-027 reset=0 SHALL force state=IDLE, mem_req=0, mem_addr=0, id_pc=0, id_inst=0, id_valid=0, exc_fetch=0, buffer cleared.
REQ-028 Reset during WAIT/DISCARD SHALL drop mem_req; a late ack after reset SHALL be ignored.

Structure
REQ-029 Reset/stall/write polarity constants, NOP encoding, bus widths and FSM state encodings SHALL live in the shared defines header.
REQ-030 SHALL be one module, no sub-modules.

Verification
REQ-031 pc=0x100, ack 3 cycles after req, rdata=0x24010005 -> mem_addr=0x100; id_pc=0x100, id_inst=0x24010005, id_valid=1 cycle after ack; stall_request low only in ack cycle.
REQ-032 pc=0x102 -> no mem_req; id_pc=0x102, id_inst=0, exc_fetch=1 next cycle.
REQ-033 req to 0x200, flush in cycle 1, ack cycle 3 rdata=0xDEADBEEF -> id_valid=0; data never presented; next req uses redirected pc.
REQ-034 ack with rdata=0x8C220004 while stall[1]=1,stall[2]=1 for 2 cycles -> IF/ID held, state HOLD; id_inst=0x8C220004 after stall clears.
REQ-035 ack with mem_err=1 at pc=0x300 -> id_inst=0, exc_fetch=1, id_pc=0x300.
REQ-036 reset=0 during WAIT, then ack -> mem_req=0 next cycle; all outputs 0; ack ignored.
